// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_pkg : shared types and constants for the instruction prefetch stage  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN     = 1'b0,
    DISCARD = 1'b1
  } pf_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/instr_prefetch_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_prefetch_buffer_if : redirect, instruction-memory and decoder bus    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface instr_prefetch_buffer_if;

  logic        load_next_pc;
  logic [31:0] next_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] npc;

  modport master (
    input  load_next_pc, next_pc, mem_ack, mem_rdata, instr_ready,
    output mem_req, mem_addr, instr_valid, instruction, pc, npc
  );

  modport slave (
    output load_next_pc, next_pc, mem_ack, mem_rdata, instr_ready,
    input  mem_req, mem_addr, instr_valid, instruction, pc, npc
  );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_fifo : DEPTH-entry FIFO of fetched {pc, npc, instr}; clear wins      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   clear,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0] count_q, count_d;
  fetch_entry_t       mem_q [DEPTH];
  fetch_entry_t       mem_d [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + c_ptr_w'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + c_cnt_w'(1);
        2'b01:   count_d = count_q - c_cnt_w'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/instr_prefetch_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_prefetch_buffer : fetch issue, redirect/discard FSM, decoder output  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module instr_prefetch_buffer
  import riscv_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  instr_prefetch_buffer_if.master bus
);

  localparam int c_cnt_w = $clog2(DEPTH) + 1;

  pf_state_t    state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  mem_addr_q, mem_addr_d;
  logic         mem_req_q, mem_req_d;

  logic               w_flush;
  logic               w_hold;
  logic               w_push;
  logic               w_pop;
  logic               w_valid;
  logic [c_cnt_w-1:0] w_count;
  logic [c_cnt_w-1:0] w_count_next;
  fetch_entry_t       w_head;
  fetch_entry_t       w_push_data;

  assign w_flush = bus.load_next_pc;
  assign w_hold  = mem_req_q & ~bus.mem_ack;
  assign w_valid = (w_count != '0);
  assign w_push  = mem_req_q & bus.mem_ack & (state_q == RUN) & ~w_flush;
  assign w_pop   = w_valid & bus.instr_ready & ~w_flush;

  assign w_push_data = '{pc: fetch_pc_q, npc: fetch_pc_q + 32'd4, instr: bus.mem_rdata};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .clear     (w_flush),
    .count     (w_count),
    .head      (w_head)
  );

  always_comb begin
    w_count_next = w_count;
    if (w_flush) begin
      w_count_next = '0;
    end else if (w_push && !w_pop) begin
      w_count_next = w_count + c_cnt_w'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = w_count - c_cnt_w'(1);
    end

    fetch_pc_d = fetch_pc_q;
    if (w_flush) begin
      fetch_pc_d = bus.next_pc & ~32'd3;
    end else if (w_push) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    // A live request is never retracted; a flush turns it into one to be waited out.
    state_d    = (w_hold && (w_flush || state_q == DISCARD)) ? DISCARD : RUN;
    mem_req_d  = w_hold | (w_count_next < c_cnt_w'(DEPTH));
    mem_addr_d = w_hold ? mem_addr_q : fetch_pc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
      mem_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.instr_valid = w_valid;
  assign bus.instruction = w_valid ? w_head.instr : NOP_INSTR;
  assign bus.pc          = w_valid ? w_head.pc    : 32'd0;
  assign bus.npc         = w_valid ? w_head.npc   : 32'd0;

endmodule
`default_nettype wire
